// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32 load/store unit with a single-port word RAM interface;
//            sub-word stores are done as read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int addr_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic [addr_width-1:0] mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_valid,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_err;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [31:0] w_store_data;

    // Width codes 011/110/111 are not loads; stores only go up to word.
    always_comb begin
        if (req_we)
            w_illegal = (req_funct3 > 3'b010);
        else
            w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end

    assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_err        = w_illegal || w_misaligned;

    assign w_shifted = r_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_data = r_rdata;
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = 32'd0;
        endcase
    end

    // Merge the new byte/halfword into the word fetched during WAIT.
    always_comb begin
        w_store_data = r_rdata;
        case (r_funct3)
            3'b000:  w_store_data[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
            3'b001:  w_store_data[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_store_data = r_wdata;
        endcase
    end

    generate
        if (addr_width > 30) begin : g_addr_wide
            assign mem_addr = {{(addr_width-30){1'b0}}, r_addr[31:2]};
        end else if (addr_width == 30) begin : g_addr_exact
            assign mem_addr = r_addr[31:2];
        end else begin : g_addr_trunc
            assign mem_addr = r_addr[addr_width+1:2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_err)
                        w_next = S_RESP;
                    else if (req_we && (req_funct3 == 3'b010))
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            S_RD: begin
                mem_rd_en = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (mem_valid)
                    w_next = r_we ? S_WR : S_RESP;
            end
            S_WR: begin
                mem_wr_en = 1'b1;
                mem_wdata = w_store_data;
                w_next    = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = (r_we || r_err) ? 32'd0 : w_load_data;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && req_valid) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_err;
            end
            if ((r_state == S_WAIT) && mem_valid)
                r_rdata <= mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed plus randomized bench for load_store_unit against a
//            byte-level reference model and a small word RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_valid = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] ram [16];

    always #5 clk = ~clk;

    load_store_unit #(.addr_width(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: operates on access size in bytes and byte offsets.
    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (we) begin
            if (f3 > 3'd2) return 1'b1;
        end else if (f3 == 3'd3 || f3 > 3'd5) begin
            return 1'b1;
        end
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
        longint w, v;
        int n, sh;
        n  = 1 << f3[1:0];
        sh = 8 * int'(a % 4);
        w  = word;
        v  = (w >> sh) & ((longint'(1) << (8 * n)) - 1);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] wd, input logic [31:0] old);
        longint o, d, mask, r;
        int n, sh;
        if (f3 == 3'd2) return wd;
        n    = 1 << f3[1:0];
        sh   = 8 * int'(a % 4);
        o    = old;
        d    = wd;
        mask = ((longint'(1) << (8 * n)) - 1) << sh;
        r    = (o & ~mask) | ((d << sh) & mask);
        return r[31:0];
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int delay);
        logic        exp_err;
        logic [31:0] word, exp_rdata, exp_wword, got_wdata;
        int          exp_lat, exp_rds, exp_wrs, exp_wr_cyc;
        int          rds, wrs, rd_cyc, wr_cyc, resp_cyc, waited;
        bit          delivered;
        logic [3:0]  rd_idx;
        rds = 0; wrs = 0; rd_cyc = -1; wr_cyc = -1; resp_cyc = -1; waited = 0;
        delivered = 1'b0; got_wdata = 32'd0; rd_idx = 4'd0;

        exp_err   = ref_err(we, f3, a);
        word      = ram[a[5:2]];
        exp_rdata = (we || exp_err) ? 32'd0 : ref_load(f3, a, word);
        exp_wword = ref_store(f3, a, wd, word);
        if (exp_err)        exp_lat = 1;
        else if (!we)       exp_lat = 3 + delay;
        else if (f3 == 3'd2) exp_lat = 2;
        else                exp_lat = 4 + delay;
        exp_rds    = (exp_err || (we && f3 == 3'd2)) ? 0 : 1;
        exp_wrs    = (!exp_err && we) ? 1 : 0;
        exp_wr_cyc = (f3 == 3'd2) ? 1 : 3 + delay;

        @(negedge clk);
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, " idle_resp"}, {31'd0, resp_valid}, 32'd0);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;

        for (int cyc = 1; cyc <= 12 && resp_cyc < 0; cyc++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            check({tag, " strobe_excl"}, {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
            if (!exp_err && cyc < exp_lat)
                check({tag, " mem_addr"}, mem_addr, a >> 2);
            if (mem_rd_en) begin
                rds++;
                rd_cyc = cyc;
                rd_idx = mem_addr[3:0];
            end
            if (mem_wr_en) begin
                wrs++;
                wr_cyc = cyc;
                got_wdata = mem_wdata;
                ram[mem_addr[3:0]] = mem_wdata;
            end else begin
                check({tag, " wdata_idle"}, mem_wdata, 32'd0);
            end
            if (resp_valid) begin
                resp_cyc = cyc;
                check({tag, " rdata"}, resp_rdata, exp_rdata);
                check({tag, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
            end
            // RAM: read data returned after 'delay' idle WAIT cycles
            mem_valid = 1'b0;
            mem_rdata = $urandom;
            if (rd_cyc > 0 && rd_cyc < cyc && !delivered) begin
                if (waited == delay) begin
                    mem_valid = 1'b1;
                    mem_rdata = ram[rd_idx];
                    delivered = 1'b1;
                end else begin
                    waited++;
                end
            end
        end
        mem_valid = 1'b0;
        check({tag, " latency"}, resp_cyc, exp_lat);
        check({tag, " rd_count"}, rds, exp_rds);
        check({tag, " wr_count"}, wrs, exp_wrs);
        if (exp_rds == 1) check({tag, " rd_cycle"}, rd_cyc, 1);
        if (exp_wrs == 1) begin
            check({tag, " wr_cycle"}, wr_cyc, exp_wr_cyc);
            check({tag, " wr_word"}, got_wdata, exp_wword);
        end
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 16; i++) ram[i] = $urandom;

        #2;
        check("reset ready", {31'd0, req_ready}, 32'd1);
        check("reset strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        check("reset resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("reset rdata", resp_rdata, 32'd0);
        check("reset wdata", mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        ram[4] = 32'h8899_AABB;
        do_req("LW 0x10", 1'b0, 3'b010, 32'h10, 32'd0, 0);
        do_req("LB 0x13", 1'b0, 3'b000, 32'h13, 32'd0, 0);
        do_req("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'd0, 0);
        do_req("LH 0x12", 1'b0, 3'b001, 32'h12, 32'd0, 1);
        do_req("SB 0x11", 1'b1, 3'b000, 32'h11, 32'h0000_00CC, 0);
        check("SB ram word", ram[4], 32'h8899_CCBB);
        do_req("LH 0x13 misalign", 1'b0, 3'b001, 32'h13, 32'd0, 0);
        do_req("SW 0x12 misalign", 1'b1, 3'b010, 32'h12, 32'h1234_5678, 0);
        do_req("load f3=011", 1'b0, 3'b011, 32'h10, 32'd0, 0);
        do_req("store f3=100", 1'b1, 3'b100, 32'h10, 32'd0, 0);
        do_req("SW 0x14", 1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF, 0);
        check("SW ram word", ram[5], 32'hDEAD_BEEF);
        ram[4] = 32'hF00D_1234;
        do_req("LHU 0x12 wait3", 1'b0, 3'b101, 32'h12, 32'd0, 3);
        do_req("SH 0x16 wait2", 1'b1, 3'b001, 32'h16, 32'h0000_5A5A, 2);

        // Abort an SH in WAIT with an asynchronous reset pulse
        ram[4] = 32'h1111_2222;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h12; req_wdata = 32'h0000_7777;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort ready", {31'd0, req_ready}, 32'd1);
        check("abort strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        check("abort resp", {30'd0, resp_valid, resp_err}, 32'd0);
        check("abort data", resp_rdata | mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_wr_en || mem_rd_en || resp_valid) bad++;
        end
        check("abort quiet", bad, 0);
        do_req("LW after abort", 1'b0, 3'b010, 32'h10, 32'd0, 0);

        for (int t = 0; t < 80; t++) begin
            do_req("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter addr_width, default 32, SHALL set the width of the word-address output mem_addr.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  execute stage presents a memory request.
REQ-005 req_ready  output  1  unit accepts a request; transfer occurs when req_valid and req_ready are both high at a rising edge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32 width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 mem_addr  output  addr_width  word address to the RAM port, equal to req_addr[31:2] zero-extended or truncated to addr_width.
REQ-011 mem_rd_en  output  1  RAM read strobe.
REQ-012 mem_wr_en  output  1  RAM write strobe.
REQ-013 mem_wdata  output  32  RAM write data.
REQ-014 mem_rdata  input  32  RAM read data.
REQ-015 mem_valid  input  1  RAM read-data-valid; RAM read latency is one cycle.
REQ-016 resp_valid  output  1  single-cycle response pulse; no backpressure.
REQ-017 resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-018 resp_err  output  1  misaligned access or illegal funct3; qualified by resp_valid.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WAIT, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 Acceptance edge: illegal funct3 (load 011/110/111, store >010) or misalignment (halfword addr[0]=1, word addr[1:0]!=00) -> RESP with resp_err=1; no memory strobe is issued.
REQ-021 Acceptance edge: load or SB/SH -> RD; SW -> WR; request fields SHALL be registered at acceptance and held until IDLE.
REQ-022 RD: mem_rd_en=1 for exactly one cycle, then -> WAIT.
REQ-023 WAIT: remain while mem_valid=0; on mem_valid=1 capture mem_rdata, then load -> RESP, sub-word store -> WR.
REQ-024 WR: mem_wr_en=1 for exactly one cycle, then -> RESP.
REQ-025 RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
REQ-026 Load extraction: lane = addr[1:0], little-endian; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-027 Sub-word store (read-modify-write): mem_wdata = captured word with only the addressed byte (SB, lane addr[1:0]) or halfword (SH, lane addr[1]) replaced by req_wdata[7:0] / [15:0]; SW writes req_wdata unchanged.
REQ-028 mem_addr SHALL be stable throughout RD, WAIT, WR; mem_wdata SHALL be 0 outside WR.
REQ-029 Latency with mem_valid in the cycle after RD, counted from the acceptance edge: resp_valid is high in cycle 3 for loads, 2 for SW, 4 for SB/SH, and 1 for errors.
REQ-030 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.
REQ-031 A new request SHALL be accepted in the cycle after RESP (back-to-back throughput: one request per latency+1 cycles).

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, and set mem_rd_en, mem_wr_en, resp_valid, resp_err to 0, resp_rdata and mem_wdata to 0, and req_ready to 1.
REQ-033 Reset asserted mid-transaction SHALL abort it: no further memory strobe, no response; the next request after release SHALL be processed normally.

Verification
REQ-034 LW addr 0x0000_0010, RAM word 4 = 0x8899_AABB -> mem_rd_en with mem_addr=4 in cycle 1; resp_rdata=0x8899_AABB, resp_err=0 in cycle 3.
REQ-035 LB addr 0x13 and LBU addr 0x13, word 4 = 0x8899_AABB -> resp_rdata 0xFFFF_FF88 and 0x0000_0088 respectively.
REQ-036 SB addr 0x11, wdata 0x0000_00CC, word 4 = 0x8899_AABB -> one read then one write of 0x8899_CCBB to mem_addr 4; resp_valid in cycle 4.
REQ-037 LH addr 0x13 and SW addr 0x12 -> resp_err=1 in cycle 1; mem_rd_en and mem_wr_en stay 0.
REQ-038 SH issued, then rst_n pulsed low during WAIT -> mem_wr_en never asserts, no resp_valid; a following LW completes correctly.
REQ-039 Hold mem_valid low for 3 cycles during WAIT on LHU addr 0x12, word 0xF00D_1234 -> state holds WAIT and mem_addr holds; resp_rdata=0x0000_F00D.
